uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, byte FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter UART_BASE, default 32'h1000_0000, AXI-Lite base address of the UART-Lite slave.
REQ-003 SHALL have parameter POLL_TIMEOUT, default 1024, max consecutive "TX full" polls before the head byte is dropped (used only with UART_TX_TIMEOUT_EN).
REQ-004 SHALL have one clock and a synchronous active-high reset, ports named as follows:
REQ-005 SHALL have port clk_i  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-007 SHALL have port byte_valid_i  input  1, byte_data_i  input  8 and byte_ready_o  output  1, forming the byte push handshake.
REQ-008 SHALL have ports aw_addr_o  output  32, aw_valid_o  output  1 and aw_ready_i  input  1 (AXI-Lite write address).
REQ-009 SHALL have ports w_data_o  output  32, w_strb_o  output  4, w_valid_o  output  1 and w_ready_i  input  1 (write data).
REQ-010 SHALL have ports b_resp_i  input  2, b_valid_i  input  1 and b_ready_o  output  1 (write response).
REQ-011 SHALL have ports ar_addr_o  output  32, ar_valid_o  output  1 and ar_ready_i  input  1 (read address).
REQ-012 SHALL have ports r_data_i  input  32, r_resp_i  input  2, r_valid_i  input  1 and r_ready_o  output  1 (read data).
REQ-013 SHALL have ports busy_o  output  1 (FIFO non-empty or FSM not IDLE) and err_o  output  1 (sticky error flag).

Function
REQ-014 SHALL accept a byte on byte_valid_i && byte_ready_o; byte_ready_o = !full, with no combinational path from pop to ready (a push while full is refused even if a pop occurs that cycle).
REQ-015 SHALL implement the FSM IDLE -> RD_STAT -> WAIT_R -> WR -> WAIT_B -> IDLE.
REQ-016 IDLE: SHALL go to RD_STAT in the cycle after the FIFO is seen non-empty; empty FIFO keeps the FSM in IDLE.
REQ-017 RD_STAT: SHALL drive ar_addr_o = UART_BASE+8 (STAT) with ar_valid_o=1 held until ar_ready_i, then go to WAIT_R.
REQ-018 WAIT_R: SHALL drive r_ready_o=1; on r_valid_i, r_resp_i==OKAY and r_data_i[3]==0 go to WR; on r_data_i[3]==1 or a non-OKAY r_resp_i go back to RD_STAT (re-poll).
REQ-019 WR: SHALL drive aw_addr_o = UART_BASE+4 (TX), w_data_o={24'b0,head byte}, w_strb_o=4'b0001.
REQ-020 WR: SHALL assert aw_valid_o and w_valid_o together and drop each independently on its own handshake; once both are complete, go to WAIT_B.
REQ-021 WAIT_B: SHALL drive b_ready_o=1; on b_valid_i pop the head byte and go to IDLE; b_resp_i!=OKAY SHALL set err_o, and the byte is still popped.
REQ-022 Latency: push at cycle N into an empty FIFO with zero-wait slave (ready=1, response one cycle after handshake) SHALL give ar_valid_o at N+1, aw_valid_o/w_valid_o at N+3, and pop at N+5.
REQ-023 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH; full when MSBs differ and LSBs are equal.
REQ-024 Push and pop in the same cycle (not full) SHALL leave the count unchanged.
REQ-025 AXI outputs SHALL be registered, and valid SHALL never drop before its handshake except on reset.

Reset
REQ-026 On rst_i=1 at a clock edge: FSM=IDLE, FIFO empty, all *_valid_o=0, b_ready_o=r_ready_o=0, err_o=0, busy_o=0, and byte_ready_o=1 from the first cycle after reset.
REQ-027 Reset mid-transaction SHALL abandon the in-flight access and discard FIFO contents; the system resets the slave together with this block.

Configuration
REQ-028 Macro UART_TX_TIMEOUT_EN defined: a counter of consecutive full/error polls (cleared on entering WR) SHALL, on reaching POLL_TIMEOUT, pop the head byte without writing, set err_o, and go to IDLE.
REQ-029 Macro UART_TX_TIMEOUT_EN undefined: no counter SHALL be present and polling SHALL continue indefinitely; err_o is then driven only by write responses.

Verification
REQ-030 Push 8'h41 into idle block, zero-wait slave, STAT=0 -> single AR to 0x1000_0008, then AW 0x1000_0004 with W 0x0000_0041 strb 0001; pop at N+5; busy_o low at N+6.
REQ-031 Push 8 bytes back-to-back with a stalled slave -> byte_ready_o low after the 8th byte; the 9th byte is refused; 8'h00..8'h07 are written in order.
REQ-032 STAT returns bit3=1 three times, then 0 -> four ARs, then one write; err_o stays 0.
REQ-033 aw_ready_i two cycles before w_ready_i -> aw_valid_o drops after its handshake, w_valid_o stays high until its own; exactly one B is consumed.
REQ-034 b_resp_i=2'b10 on a write -> err_o=1, sticky until reset; the next byte proceeds normally.
REQ-035 With UART_TX_TIMEOUT_EN and POLL_TIMEOUT=4, STAT stuck full -> 4 polls, byte dropped, no AW, err_o=1; assert rst_i mid-WR -> all valids 0 on the next cycle.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: byte FIFO drained into a UART-Lite TX register over AXI-Lite, polling STAT first.
// Optional macro UART_TX_TIMEOUT_EN: drop the head byte after POLL_TIMEOUT consecutive busy/error polls.
module uart_tx_ctrl #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] UART_BASE    = 32'h1000_0000,
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic [31:0] aw_addr_o,
  output logic        aw_valid_o,
  input  logic        aw_ready_i,
  output logic [31:0] w_data_o,
  output logic [3:0]  w_strb_o,
  output logic        w_valid_o,
  input  logic        w_ready_i,
  input  logic [1:0]  b_resp_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  output logic [31:0] ar_addr_o,
  output logic        ar_valid_o,
  input  logic        ar_ready_i,
  input  logic [31:0] r_data_i,
  input  logic [1:0]  r_resp_i,
  input  logic        r_valid_i,
  output logic        r_ready_o,
  output logic        busy_o,
  output logic        err_o
);
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [31:0] STAT_ADDR = UART_BASE + 32'd8;
  localparam logic [31:0] TX_ADDR   = UART_BASE + 32'd4;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {S_IDLE, S_RD_STAT, S_WAIT_R, S_WR, S_WAIT_B} state_t;

  state_t      r_state;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [31:0] r_ar_addr;
  logic        r_ar_valid;
  logic        r_r_ready;
  logic [31:0] r_aw_addr;
  logic        r_aw_valid;
  logic [31:0] r_w_data;
  logic [3:0]  r_w_strb;
  logic        r_w_valid;
  logic        r_b_ready;
  logic        r_err;
  logic        r_busy;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_poll_fail;
  logic        w_drop;
  logic        w_aw_done;
  logic        w_w_done;
  logic [7:0]  w_head;
  logic        w_unused_rdata;

`ifdef UART_TX_TIMEOUT_EN
  localparam int unsigned CW         = $clog2(POLL_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(POLL_TIMEOUT - 1);
  logic [CW-1:0] r_poll_cnt;
`endif

  // FIFO status, handshake qualifiers and the pop/drop decision
  always_comb begin
    w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_empty     = (r_wr_ptr == r_rd_ptr);
    w_push      = byte_valid_i && !w_full;
    w_head      = r_mem[r_rd_ptr[AW-1:0]];
    w_poll_fail = (r_state == S_WAIT_R) && r_valid_i && ((r_resp_i != RESP_OKAY) || r_data_i[3]);
    w_aw_done   = !r_aw_valid || aw_ready_i;
    w_w_done    = !r_w_valid || w_ready_i;
`ifdef UART_TX_TIMEOUT_EN
    w_drop      = w_poll_fail && (r_poll_cnt == CNT_LAST);
`else
    w_drop      = 1'b0;
`endif
    w_pop       = ((r_state == S_WAIT_B) && b_valid_i) || w_drop;
  end

  // Byte FIFO storage and wrap-around pointers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= byte_data_i;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

`ifdef UART_TX_TIMEOUT_EN
  // Consecutive failed STAT polls; cleared whenever a poll ends in a write or a drop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_poll_cnt <= '0;
    end else if (w_poll_fail && !w_drop) begin
      r_poll_cnt <= r_poll_cnt + CNT_ONE;
    end else if ((r_state == S_WAIT_R) && r_valid_i) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt;
    end
  end
`endif

  // Bus sequencing FSM with registered AXI-Lite outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_ar_addr  <= '0;
      r_ar_valid <= 1'b0;
      r_r_ready  <= 1'b0;
      r_aw_addr  <= '0;
      r_aw_valid <= 1'b0;
      r_w_data   <= '0;
      r_w_strb   <= 4'b0000;
      r_w_valid  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_busy <= (r_state != S_IDLE) || !w_empty || w_push;
      case (r_state)
        S_IDLE: begin
          // Looking at the incoming push too lets AR go out the cycle after it
          if (!w_empty || w_push) begin
            r_ar_addr  <= STAT_ADDR;
            r_ar_valid <= 1'b1;
            r_state    <= S_RD_STAT;
          end
        end
        S_RD_STAT: begin
          if (ar_ready_i) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          if (r_valid_i) begin
            r_r_ready <= 1'b0;
            if (w_drop) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else if (w_poll_fail) begin
              r_ar_valid <= 1'b1;
              r_state    <= S_RD_STAT;
            end else begin
              r_aw_addr  <= TX_ADDR;
              r_aw_valid <= 1'b1;
              r_w_data   <= {24'h00_0000, w_head};
              r_w_strb   <= 4'b0001;
              r_w_valid  <= 1'b1;
              r_state    <= S_WR;
            end
          end
        end
        S_WR: begin
          if (r_aw_valid && aw_ready_i) begin
            r_aw_valid <= 1'b0;
          end
          if (r_w_valid && w_ready_i) begin
            r_w_valid <= 1'b0;
          end
          if (w_aw_done && w_w_done) begin
            r_b_ready <= 1'b1;
            r_state   <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (b_valid_i) begin
            r_b_ready <= 1'b0;
            if (b_resp_i != RESP_OKAY) begin
              r_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ar_valid <= 1'b0;
          r_r_ready  <= 1'b0;
          r_aw_valid <= 1'b0;
          r_w_valid  <= 1'b0;
          r_b_ready  <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign w_unused_rdata = ^{r_data_i[31:4], r_data_i[2:0]};

  assign byte_ready_o = !w_full;
  assign ar_addr_o    = r_ar_addr;
  assign ar_valid_o   = r_ar_valid;
  assign r_ready_o    = r_r_ready;
  assign aw_addr_o    = r_aw_addr;
  assign aw_valid_o   = r_aw_valid;
  assign w_data_o     = r_w_data;
  assign w_strb_o     = r_w_strb;
  assign w_valid_o    = r_w_valid;
  assign b_ready_o    = r_b_ready;
  assign busy_o       = r_busy;
  assign err_o        = r_err;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: reactive AXI-Lite slave model with a write scoreboard,
// a table of single-byte transactions, and hand-written latency, backpressure and reset sequences.
module tb_uart_tx_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic [31:0] aw_addr_o;
  logic        aw_valid_o;
  logic        aw_ready_i;
  logic [31:0] w_data_o;
  logic [3:0]  w_strb_o;
  logic        w_valid_o;
  logic        w_ready_i;
  logic [1:0]  b_resp_i;
  logic        b_valid_i;
  logic        b_ready_o;
  logic [31:0] ar_addr_o;
  logic        ar_valid_o;
  logic        ar_ready_i;
  logic [31:0] r_data_i;
  logic [1:0]  r_resp_i;
  logic        r_valid_i;
  logic        r_ready_o;
  logic        busy_o;
  logic        err_o;

  uart_tx_ctrl #(.FIFO_DEPTH(8), .UART_BASE(32'h1000_0000), .POLL_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .aw_addr_o(aw_addr_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
    .ar_addr_o(ar_addr_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  // slave configuration, written by the main sequence
  bit stall = 1'b0;
  bit stat_stuck = 1'b0;
  int stat_full = 0;
  int bad_resp = 0;
  int aw_delay = 0;
  int w_delay = 0;
  logic [1:0] cur_bresp = 2'b00;

  // slave statistics
  int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, drop_errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  // AXI-Lite slave: samples at the rising edge, drives the next cycle 1 time unit later
  initial begin : axi_slave
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bit r_go, b_go, aw_got, w_got, ar_pend, aw_pend, w_pend;
    int aw_cnt, w_cnt;
    logic [31:0] r_dat, w_exp;
    logic [1:0] r_rsp;
    r_go = 0; b_go = 0; aw_got = 0; w_got = 0; ar_pend = 0; aw_pend = 0; w_pend = 0;
    aw_cnt = 0; w_cnt = 0; r_dat = 32'h0; r_rsp = 2'b00;
    ar_ready_i = 1'b0; aw_ready_i = 1'b0; w_ready_i = 1'b0;
    r_valid_i = 1'b0; r_data_i = 32'h0; r_resp_i = 2'b00; b_valid_i = 1'b0; b_resp_i = 2'b00;
    forever begin
      @(posedge clk_i);
      ar_hs = ar_valid_o && ar_ready_i;
      r_hs  = r_valid_i && r_ready_o;
      aw_hs = aw_valid_o && aw_ready_i;
      w_hs  = w_valid_o && w_ready_i;
      b_hs  = b_valid_i && b_ready_o;
      if (rst_i) begin
        r_go = 0; b_go = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
        ar_pend = 0; aw_pend = 0; w_pend = 0;
        exp_q.delete();
      end else begin
        if (ar_pend && !ar_valid_o) drop_errs++;
        if (aw_pend && !aw_valid_o) drop_errs++;
        if (w_pend && !w_valid_o) drop_errs++;
        if (r_hs) r_go = 0;
        if (b_hs) begin b_go = 0; n_b++; end
        if (ar_hs) begin
          n_ar++;
          check("ar_addr", ar_addr_o, 32'h1000_0008);
          if (bad_resp > 0) begin r_dat = 32'h0; r_rsp = 2'b10; bad_resp--; end
          else if (stat_stuck || stat_full > 0) begin
            r_dat = 32'h8; r_rsp = 2'b00;
            if (stat_full > 0) stat_full--;
          end else begin r_dat = 32'h0; r_rsp = 2'b00; end
          r_go = 1;
        end
        if (aw_hs) begin
          n_aw++; aw_got = 1; aw_cnt = 0;
          check("aw_addr", aw_addr_o, 32'h1000_0004);
        end else if (aw_valid_o) aw_cnt++;
        if (w_hs) begin
          n_w++; w_got = 1; w_cnt = 0;
          check("w_strb", {28'h0, w_strb_o}, 32'h1);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL w_unexpected: actual data 0x%0h required no write", w_data_o);
          end else begin
            w_exp = exp_q.pop_front();
            check("w_data", w_data_o, w_exp);
          end
        end else if (w_valid_o) w_cnt++;
        if (aw_got && w_got) begin b_go = 1; aw_got = 0; w_got = 0; end
        ar_pend = ar_valid_o && !ar_hs;
        aw_pend = aw_valid_o && !aw_hs;
        w_pend  = w_valid_o && !w_hs;
      end
      #1;
      ar_ready_i = !stall;
      aw_ready_i = !stall && (aw_cnt >= aw_delay);
      w_ready_i  = !stall && (w_cnt >= w_delay);
      r_valid_i  = r_go;
      r_data_i   = r_dat;
      r_resp_i   = r_rsp;
      b_valid_i  = b_go;
      b_resp_i   = cur_bresp;
    end
  end

  task automatic push_byte(input logic [7:0] d, output bit acc);
    byte_valid_i = 1'b1;
    byte_data_i  = d;
    @(posedge clk_i);
    acc = byte_ready_o;
    if (acc) exp_q.push_back({24'h0, d});
    #1 byte_valid_i = 1'b0;
  endtask

  task automatic push_wait(input logic [7:0] d);
    bit acc = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) push_byte(d, acc);
    check("push_accept_timeout", {31'h0, acc}, 32'h1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk_i);
      if (!busy_o) ok = 1'b1;
    end
    check(name, {31'h0, ok}, 32'h1);
  endtask

  typedef struct {
    logic [7:0] data;
    int         n_bad;
    int         n_full;
    logic [1:0] bresp;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    bit acc;
    bit split;
    bit seen;
    int ar0, aw0, w0, b0;
    vecs[0] = '{8'h41, 0, 0, 2'b00, 1'b0};
    vecs[1] = '{8'h5A, 0, 3, 2'b00, 1'b0};
    vecs[2] = '{8'hA5, 1, 1, 2'b00, 1'b0};
    vecs[3] = '{8'h3C, 0, 0, 2'b10, 1'b1};
    vecs[4] = '{8'hC3, 0, 0, 2'b00, 1'b1};
    vecs[5] = '{8'hFF, 2, 0, 2'b00, 1'b1};

    rst_i = 1'b1; byte_valid_i = 1'b0; byte_data_i = 8'h00;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ar_valid", {31'h0, ar_valid_o}, 32'h0);
    check("rst_aw_valid", {31'h0, aw_valid_o}, 32'h0);
    check("rst_w_valid", {31'h0, w_valid_o}, 32'h0);
    check("rst_b_ready", {31'h0, b_ready_o}, 32'h0);
    check("rst_r_ready", {31'h0, r_ready_o}, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_byte_ready", {31'h0, byte_ready_o}, 32'h1);

    // zero-wait latency: push at N, AR at N+1, AW/W at N+3, pop at N+5, idle at N+6
    ar0 = n_ar;
    push_byte(8'h41, acc);
    check("lat_accept", {31'h0, acc}, 32'h1);
    @(negedge clk_i);
    check("lat_n1_ar_valid", {31'h0, ar_valid_o}, 32'h1);
    check("lat_n1_busy", {31'h0, busy_o}, 32'h1);
    @(negedge clk_i);
    check("lat_n2_ar_valid", {31'h0, ar_valid_o}, 32'h0);
    check("lat_n2_r_ready", {31'h0, r_ready_o}, 32'h1);
    check("lat_n2_aw_valid", {31'h0, aw_valid_o}, 32'h0);
    @(negedge clk_i);
    check("lat_n3_aw_valid", {31'h0, aw_valid_o}, 32'h1);
    check("lat_n3_w_valid", {31'h0, w_valid_o}, 32'h1);
    check("lat_n3_w_data", w_data_o, 32'h0000_0041);
    @(negedge clk_i);
    check("lat_n4_b_ready", {31'h0, b_ready_o}, 32'h1);
    check("lat_n4_aw_valid", {31'h0, aw_valid_o}, 32'h0);
    @(negedge clk_i);
    check("lat_n5_b_ready", {31'h0, b_ready_o}, 32'h0);
    check("lat_n5_busy", {31'h0, busy_o}, 32'h1);
    @(negedge clk_i);
    check("lat_n6_busy", {31'h0, busy_o}, 32'h0);
    check("lat_ar_count", n_ar - ar0, 32'd1);

    // table of single-byte transactions with varying STAT and B responses
    for (int i = 0; i < 6; i++) begin
      bad_resp = vecs[i].n_bad; stat_full = vecs[i].n_full; cur_bresp = vecs[i].bresp;
      ar0 = n_ar; aw0 = n_aw; b0 = n_b;
      push_byte(vecs[i].data, acc);
      check("vec_accept", {31'h0, acc}, 32'h1);
      wait_idle("vec_idle_timeout");
      check("vec_ar_count", n_ar - ar0, 32'(1 + vecs[i].n_bad + vecs[i].n_full));
      check("vec_aw_count", n_aw - aw0, 32'd1);
      check("vec_b_count", n_b - b0, 32'd1);
      check("vec_err", {31'h0, err_o}, {31'h0, vecs[i].exp_err});
    end
    cur_bresp = 2'b00;

    // AW accepted two cycles before W
    aw_delay = 1; w_delay = 3; b0 = n_b; split = 1'b0;
    push_byte(8'h99, acc);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (!aw_valid_o && w_valid_o) split = 1'b1;
    end
    wait_idle("split_idle_timeout");
    check("split_seen", {31'h0, split}, 32'h1);
    check("split_b_count", n_b - b0, 32'd1);
    aw_delay = 0; w_delay = 0;

    // stalled slave: FIFO fills at 8, 9th refused, then drains in order
    stall = 1'b1; w0 = n_w;
    for (int i = 0; i < 8; i++) push_byte(8'(i), acc);
    @(negedge clk_i);
    check("full_byte_ready", {31'h0, byte_ready_o}, 32'h0);
    push_byte(8'h08, acc);
    check("full_ninth_refused", {31'h0, acc}, 32'h0);
    @(negedge clk_i);
    check("full_ar_held", {31'h0, ar_valid_o}, 32'h1);
    stall = 1'b0;
    for (int i = 8; i < 12; i++) push_wait(8'(i));
    wait_idle("drain_idle_timeout");
    check("drain_write_count", n_w - w0, 32'd12);
    check("drain_sb_empty", exp_q.size(), 32'd0);

    // reset while W is stalled in the write phase
    check("err_sticky", {31'h0, err_o}, 32'h1);
    w_delay = 100; seen = 1'b0;
    push_byte(8'h55, acc);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (w_valid_o && !aw_valid_o) seen = 1'b1;
    end
    check("midwr_reached", {31'h0, seen}, 32'h1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    w_delay = 0;
    @(negedge clk_i);
    check("midrst_ar_valid", {31'h0, ar_valid_o}, 32'h0);
    check("midrst_aw_valid", {31'h0, aw_valid_o}, 32'h0);
    check("midrst_w_valid", {31'h0, w_valid_o}, 32'h0);
    check("midrst_b_ready", {31'h0, b_ready_o}, 32'h0);
    check("midrst_r_ready", {31'h0, r_ready_o}, 32'h0);
    check("midrst_err", {31'h0, err_o}, 32'h0);
    check("midrst_busy", {31'h0, busy_o}, 32'h0);
    check("midrst_byte_ready", {31'h0, byte_ready_o}, 32'h1);

    // normal transfer after reset
    w0 = n_w;
    push_byte(8'h7E, acc);
    wait_idle("post_rst_idle_timeout");
    check("post_rst_write", n_w - w0, 32'd1);
    check("post_rst_err", {31'h0, err_o}, 32'h0);

`ifdef UART_TX_TIMEOUT_EN
    // STAT stuck full: four polls, byte dropped without a write
    stat_stuck = 1'b1; ar0 = n_ar; aw0 = n_aw;
    push_byte(8'h66, acc);
    wait_idle("timeout_idle_timeout");
    check("timeout_ar_count", n_ar - ar0, 32'd4);
    check("timeout_aw_count", n_aw - aw0, 32'd0);
    check("timeout_err", {31'h0, err_o}, 32'h1);
    check("timeout_dropped", exp_q.size(), 32'd1);
    exp_q.delete();
    stat_stuck = 1'b0;
`endif

    check("sb_empty", exp_q.size(), 32'd0);
    check("valid_drops", drop_errs, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
